// File: rtl/fft_bf_seq.sv
`default_nettype none
// ============================================================================
// Module   : fft_bf_seq
// Purpose  : In-place radix-2 decimation-in-frequency FFT address sequencer.
//            Issues one butterfly read per clock: operand addresses A/B and
//            the twiddle index. Emits the matching write-back strobe and
//            addresses LAT cycles later. Between stages it drains for LAT
//            cycles, so every write of stage s lands before stage s+1 reads.
// Ports    : clk, reset (async, active-high), start (1-cycle request)
//            busy, done, stage           - transform status
//            rd_en, rd_addr_a/b, tw_idx  - operand read side
//            wr_en, wr_addr_a/b          - write-back side (rd_* delayed LAT)
// Revision : 1.0 - initial release
// ============================================================================
module fft_bf_seq #(
  parameter int LOGN = 3,
  parameter int LAT  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [3:0]      stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_idx,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int HALF_W = LOGN - 1;
  localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int PIPE_W = 1 + 2 * LOGN;

  localparam logic [HALF_W-1:0] c_J_LAST   = '1;               // N/2-1
  localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(LAT - 1);
  localparam logic [3:0]        c_S_LAST   = 4'(LOGN - 1);
  localparam logic [LOGN-1:0]   c_ONE_N    = {{(LOGN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [HALF_W-1:0]  r_j;
  logic [3:0]         r_s;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_rd_en;
  logic [LOGN-1:0]    r_rd_addr_a;
  logic [LOGN-1:0]    r_rd_addr_b;
  logic [HALF_W-1:0]  r_tw_idx;
  logic [LAT-1:0][PIPE_W-1:0] r_pipe;

  state_t             w_state_nxt;
  logic [HALF_W-1:0]  w_j_nxt;
  logic [3:0]         w_s_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_issue;
  logic [3:0]         w_shift;
  logic [LOGN-1:0]    w_span;
  logic [LOGN-1:0]    w_low;
  logic [LOGN-1:0]    w_jx;
  logic [LOGN-1:0]    w_addr_a;
  logic [LOGN-1:0]    w_addr_b;
  logic [HALF_W-1:0]  w_tw;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_s_nxt     = r_s;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_j_nxt     = '0;
          w_s_nxt     = '0;
        end
      end
      S_RUN: begin
        if (r_j == c_J_LAST) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_j_nxt = r_j + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == c_CNT_LAST) begin
          if (r_s < c_S_LAST) begin
            w_state_nxt = S_RUN;
            w_s_nxt     = r_s + 1'b1;
            w_j_nxt     = '0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address generation for the butterfly about to be issued. Outputs are
  // registered, so addresses are derived from the next j/s values.
  // A = j with a zero bit inserted at position LOGN-1-s; B = A + span.
  // --------------------------------------------------------------------------
  always_comb begin
    w_issue  = (w_state_nxt == S_RUN);
    w_shift  = c_S_LAST - w_s_nxt;
    w_span   = c_ONE_N << w_shift;
    w_low    = w_span - c_ONE_N;
    w_jx     = {1'b0, w_j_nxt};
    w_addr_a = ((w_jx & ~w_low) << 1) | (w_jx & w_low);
    w_addr_b = w_addr_a | w_span;
    // pos < span = 2^(LOGN-1-s), so pos << s always fits in LOGN-1 bits
    w_tw     = (w_j_nxt & w_low[HALF_W-1:0]) << w_s_nxt;
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_j         <= '0;
      r_s         <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr_a <= '0;
      r_rd_addr_b <= '0;
      r_tw_idx    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_j         <= w_j_nxt;
      r_s         <= w_s_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      r_done      <= (w_state_nxt == S_DONE);
      r_rd_en     <= w_issue;
      r_rd_addr_a <= w_issue ? w_addr_a : '0;
      r_rd_addr_b <= w_issue ? w_addr_b : '0;
      r_tw_idx    <= w_issue ? w_tw : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Write-back delay line: {valid, addr_a, addr_b}, shifts every cycle.
  // Tap LAT-1 presents the read issued LAT cycles earlier.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= {r_rd_en, r_rd_addr_a, r_rd_addr_b};
      for (int k = 1; k < LAT; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign stage     = r_s;
  assign rd_en     = r_rd_en;
  assign rd_addr_a = r_rd_addr_a;
  assign rd_addr_b = r_rd_addr_b;
  assign tw_idx    = r_tw_idx;
  assign wr_en     = r_pipe[LAT-1][PIPE_W-1];
  assign wr_addr_a = r_pipe[LAT-1][2*LOGN-1:LOGN];
  assign wr_addr_b = r_pipe[LAT-1][LOGN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fft_bf_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bf_seq
// Purpose  : Self-checking bench for fft_bf_seq. One instance with N=8,
//            LAT=4 (table-driven address vectors), one with N=16, LAT=1
//            (span/group reference model). Covers reset, restart-while-busy,
//            back-to-back transforms and asynchronous mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bf_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: LOGN=3, LAT=4 ----------------
  logic       rst_a, start_a;
  logic       a_busy, a_done, a_rd_en, a_wr_en;
  logic [3:0] a_stage;
  logic [2:0] a_ra, a_rb, a_wa, a_wb;
  logic [1:0] a_tw;

  fft_bf_seq #(.LOGN(3), .LAT(4)) u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a),
    .busy(a_busy), .done(a_done), .stage(a_stage),
    .rd_en(a_rd_en), .rd_addr_a(a_ra), .rd_addr_b(a_rb), .tw_idx(a_tw),
    .wr_en(a_wr_en), .wr_addr_a(a_wa), .wr_addr_b(a_wb)
  );

  // ---------------- DUT B: LOGN=4, LAT=1 ----------------
  logic       rst_b, start_b;
  logic       b_busy, b_done, b_rd_en, b_wr_en;
  logic [3:0] b_stage;
  logic [3:0] b_ra, b_rb, b_wa, b_wb;
  logic [2:0] b_tw;

  fft_bf_seq #(.LOGN(4), .LAT(1)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b),
    .busy(b_busy), .done(b_done), .stage(b_stage),
    .rd_en(b_rd_en), .rd_addr_a(b_ra), .rd_addr_b(b_rb), .tw_idx(b_tw),
    .wr_en(b_wr_en), .wr_addr_a(b_wa), .wr_addr_b(b_wb)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int s;
    int a;
    int b;
    int tw;
  } rdvec_t;

  rdvec_t tbl8 [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle t+1 (start sampled at edge t). Returns in cycle t+26.
  task automatic run8(input bit restarts);
    for (int off = 1; off <= 25; off++) begin
      int exp_rd = 0;
      int ridx   = 0;
      int w      = off - 4;
      int exp_wr = 0;
      int widx   = 0;
      if (off <= 24 && ((off - 1) % 8) < 4) begin
        exp_rd = 1;
        ridx   = ((off - 1) / 8) * 4 + (off - 1) % 8;
      end
      if (w >= 1 && w <= 24 && ((w - 1) % 8) < 4) begin
        exp_wr = 1;
        widx   = ((w - 1) / 8) * 4 + (w - 1) % 8;
      end
      chk($sformatf("a_rd_en@%0d", off), a_rd_en, exp_rd);
      if (exp_rd == 1) begin
        chk($sformatf("a_rd_addr_a@%0d", off), a_ra, tbl8[ridx].a);
        chk($sformatf("a_rd_addr_b@%0d", off), a_rb, tbl8[ridx].b);
        chk($sformatf("a_tw_idx@%0d", off), a_tw, tbl8[ridx].tw);
        chk($sformatf("a_stage@%0d", off), a_stage, tbl8[ridx].s);
      end
      chk($sformatf("a_wr_en@%0d", off), a_wr_en, exp_wr);
      if (exp_wr == 1) begin
        chk($sformatf("a_wr_addr_a@%0d", off), a_wa, tbl8[widx].a);
        chk($sformatf("a_wr_addr_b@%0d", off), a_wb, tbl8[widx].b);
      end
      chk($sformatf("a_busy@%0d", off), a_busy, (off <= 24) ? 1 : 0);
      chk($sformatf("a_done@%0d", off), a_done, (off == 25) ? 1 : 0);
      chk($sformatf("a_rd_wr_overlap@%0d", off), a_rd_en & a_wr_en, 0);
      if (restarts && (off == 3 || off == 12)) start_a = 1'b1;
      step();
      start_a = 1'b0;
    end
    chk("a_done_after", a_done, 0);
    chk("a_busy_after", a_busy, 0);
  endtask

  // Called in cycle t+1 on DUT B; checks against a span/group model.
  task automatic run16();
    for (int off = 1; off <= 37; off++) begin
      int exp_rd = 0;
      int s      = (off - 1) / 9;
      int j      = (off - 1) % 9;
      int span, pos, grp, ea;
      int exp_wr = 0;
      if (off <= 36 && j < 8) exp_rd = 1;
      if (off >= 2 && off <= 37 && ((off - 2) % 9) < 8) exp_wr = 1;
      chk($sformatf("b_rd_en@%0d", off), b_rd_en, exp_rd);
      if (exp_rd == 1) begin
        span = 16 >> (s + 1);
        pos  = j % span;
        grp  = j / span;
        ea   = grp * 2 * span + pos;
        chk($sformatf("b_rd_addr_a@%0d", off), b_ra, ea);
        chk($sformatf("b_rd_addr_b@%0d", off), b_rb, ea + span);
        chk($sformatf("b_tw_idx@%0d", off), b_tw, (pos << s) & 7);
        chk($sformatf("b_stage@%0d", off), b_stage, s);
      end
      if (off >= 2 && exp_wr == 1) begin
        s    = (off - 2) / 9;
        j    = (off - 2) % 9;
        span = 16 >> (s + 1);
        ea   = (j / span) * 2 * span + (j % span);
        chk($sformatf("b_wr_addr_a@%0d", off), b_wa, ea);
        chk($sformatf("b_wr_addr_b@%0d", off), b_wb, ea + span);
      end
      chk($sformatf("b_wr_en@%0d", off), b_wr_en, exp_wr);
      chk($sformatf("b_done@%0d", off), b_done, (off == 37) ? 1 : 0);
      chk($sformatf("b_busy@%0d", off), b_busy, (off <= 36) ? 1 : 0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl8[0]  = '{0, 0, 4, 0};
    tbl8[1]  = '{0, 1, 5, 1};
    tbl8[2]  = '{0, 2, 6, 2};
    tbl8[3]  = '{0, 3, 7, 3};
    tbl8[4]  = '{1, 0, 2, 0};
    tbl8[5]  = '{1, 1, 3, 2};
    tbl8[6]  = '{1, 4, 6, 0};
    tbl8[7]  = '{1, 5, 7, 2};
    tbl8[8]  = '{2, 0, 1, 0};
    tbl8[9]  = '{2, 2, 3, 0};
    tbl8[10] = '{2, 4, 5, 0};
    tbl8[11] = '{2, 6, 7, 0};

    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    step();
    step();
    rst_a = 1'b0; rst_b = 1'b0;

    // Idle after reset: every output of both instances at zero.
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a_idle_outputs@%0d", i),
          int'({a_busy, a_done, a_stage, a_rd_en, a_ra, a_rb, a_tw,
                a_wr_en, a_wa, a_wb}), 0);
      chk($sformatf("b_idle_outputs@%0d", i),
          int'({b_busy, b_done, b_stage, b_rd_en, b_ra, b_rb, b_tw,
                b_wr_en, b_wa, b_wb}), 0);
      step();
    end

    // Plain transform.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    run8(1'b0);

    // Start one cycle after done, with extra starts while busy.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    run8(1'b1);

    // Asynchronous reset in the middle of stage 1.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("a_mid_rd_en_before_reset", a_rd_en, 1);
    chk("a_mid_stage_before_reset", a_stage, 1);
    #2;
    rst_a = 1'b1;
    #1;
    chk("a_async_busy", a_busy, 0);
    chk("a_async_done", a_done, 0);
    chk("a_async_stage", a_stage, 0);
    chk("a_async_rd_en", a_rd_en, 0);
    chk("a_async_rd_addr", int'({a_ra, a_rb, a_tw}), 0);
    chk("a_async_wr_en", a_wr_en, 0);
    chk("a_async_wr_addr", int'({a_wa, a_wb}), 0);
    step();
    step();
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a_post_reset_wr_en@%0d", i), a_wr_en, 0);
      chk($sformatf("a_post_reset_rd_en@%0d", i), a_rd_en, 0);
      step();
    end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    run8(1'b0);

    // Larger transform, single-cycle latency.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    run16();
    chk("b_done_after", b_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_bf_seq.md
# fft_bf_seq

In-place radix-2 decimation-in-frequency FFT sequencer that sits directly upstream of the butterfly processor. It generates the per-cycle operand read addresses (A, B) for the data memory and the twiddle ROM index that selects c/cps/cms. It also generates the delayed write-back addresses for the butterfly's D (sum) and E (twiddled difference) results. The sequencer issues one butterfly per clock, with a pipeline drain between stages, so that in-place read-after-write ordering is guaranteed.

## Interface
Parameters:
- LOGN, 3: log2 of FFT length N. Legal range 2..15.
- LAT, 4: cycles from rd_en to the matching wr_en. This covers memory read, butterfly input register and multiplier output register. Minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run a full N-point transform.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final write-back.
- stage  out  4  current stage index s, 0..LOGN-1.
- rd_en  out  1  operand read strobe for the data memory and twiddle ROM.
- rd_addr_a  out  LOGN  A operand address.
- rd_addr_b  out  LOGN  B operand address.
- tw_idx  out  LOGN-1  twiddle ROM index k, where W_N^k feeds c/cps/cms.
- wr_en  out  1  write-back strobe, equal to rd_en delayed LAT cycles.
- wr_addr_a  out  LOGN  destination of the D result. Equals rd_addr_a delayed LAT cycles.
- wr_addr_b  out  LOGN  destination of the E result. Equals rd_addr_b delayed LAT cycles.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start=1, go to RUN. Clear j and s to 0 and set busy=1.
  - RUN: rd_en=1 every cycle. The butterfly counter j (LOGN-1 bits) counts 0..N/2-1. When j=N/2-1, go to DRAIN.
  - DRAIN: rd_en=0 for exactly LAT cycles; a counter counts 0..LAT-1. On exit:
    - if s<LOGN-1: increment s, clear j, go to RUN;
    - otherwise go to DONE.
  - DONE: one cycle. done=1, busy=0, then go to IDLE.
- Address generation for stage s, with span = N>>(s+1), pos = j mod span, grp = j / span:
  - rd_addr_a = grp*2*span + pos. This is j with a 0 bit inserted at bit position LOGN-1-s.
  - rd_addr_b = rd_addr_a + span.
  - tw_idx = pos << s, truncated to LOGN-1 bits.
- Write-back pipeline: a LAT-deep shift register of {valid, addr_a, addr_b}, advanced every cycle regardless of state.
- start while busy=1 is ignored and has no effect on any output.
- Reset, asynchronous and at any time including mid-transform, immediately forces:
  - state to IDLE;
  - busy, done, rd_en and wr_en to 0;
  - stage, all addresses and tw_idx to 0;
  - every pipeline valid bit to 0.
  - No write-back occurs after reset.
- The FSM responds to start on the first edge after reset deassertion.

## Timing
- Outputs are registered.
- Cycle t is the edge where start=1 is sampled in IDLE.
  - busy rises at t+1.
  - The first rd_en is at t+1.
- Each stage is N/2 rd_en cycles followed by LAT idle cycles.
- Total: done at t + LOGN*(N/2 + LAT) + 1. busy falls in the same cycle done rises.
  - Example, N=8, LAT=4: reads at t+1..4, 9..12, 17..20; done at t+25.
- The last write of stage s precedes the first read of stage s+1 by exactly 1 cycle. No read-after-write overlap occurs.
- wr_en/wr_addr_* at cycle c equal rd_en/rd_addr_* at cycle c-LAT.
- stage updates in the same cycle as the first read of the new stage, and holds through DRAIN.

## Test plan
- Reset, then idle 10 cycles -> all outputs 0; no rd_en or wr_en activity.
- N=8, LAT=4, start pulse -> the (rd_addr_a, rd_addr_b, tw_idx) sequence must be exactly:
  - stage 0: (0,4,0), (1,5,1), (2,6,2), (3,7,3);
  - stage 1: (0,2,0), (1,3,2), (4,6,0), (5,7,2);
  - stage 2: (0,1,0), (2,3,0), (4,5,0), (6,7,0).
  - rd_en pattern as in Timing; done=1 only at t+25.
- Same run -> wr_en and wr_addr_* equal rd_en and rd_addr_* shifted by exactly 4 cycles. No wr_en occurs in a cycle where rd_en of the next stage is 1.
- start re-asserted at t+3 and t+12 -> ignored; the sequence is identical to the previous test. A start one cycle after done begins a new transform.
- Reset asserted at t+10 (mid stage 1) -> all outputs 0 asynchronously, before the next edge. No wr_en after reset. A new start runs the full sequence from stage 0.
- LOGN=4, LAT=1 -> 8 reads per stage. Stage 3 pairs are (2i, 2i+1) with tw_idx=0. Stage 0 tw_idx runs 0..7. done at t+37.
